// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the bus-based datapath.
// Outputs are a pure decode of the state register (plus mem_ready for MDRin).
module datapath_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned NREGS       = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [31:0]      ir,
   output logic             PCout,
   output logic             PCin,
   output logic             IncPC,
   output logic             MARin,
   output logic             MDRread,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             RYin,
   output logic             RZinLo,
   output logic             RZoutLo,
   output logic [NREGS-1:0] reg_in,
   output logic [NREGS-1:0] reg_out,
   output logic [4:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic             fault,
   output logic             illegal
);

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StHalt, StFault
   } state_e;

   localparam logic [4:0] OpRLast = 5'b01000;
   localparam logic [4:0] OpNop   = 5'b11010;
   localparam logic [4:0] OpHalt  = 5'b11011;

   state_e     state_q, state_d;
   logic [7:0] count_q, count_d;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       unused_ir;

   assign op        = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];

   // Register indices beyond NREGS simply select nothing.
   function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
      logic [NREGS-1:0] res;
      res = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         res[i] = (32'(idx) == i);
      end
      return res;
   endfunction

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= StIdle;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      MDRread = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      RYin    = 1'b0;
      RZinLo  = 1'b0;
      RZoutLo = 1'b0;
      reg_in  = '0;
      reg_out = '0;
      alu_op  = 5'd0;
      busy    = 1'b0;
      done    = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      illegal = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d = StT0;
            end
         end
         StT0: begin
            busy    = 1'b1;
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            RZinLo  = 1'b1;
            count_d = 8'd0;
            state_d = StT1;
         end
         StT1: begin
            busy    = 1'b1;
            MDRread = 1'b1;
            RZoutLo = 1'b1;
            // Counter is zero only on the first wait cycle, so PC loads once.
            PCin    = (count_q == 8'd0);
            if (mem_ready) begin
               MDRin   = 1'b1;
               state_d = StT2;
            end else begin
               count_d = count_q + 8'd1;
               if (count_d == 8'(MEM_TIMEOUT)) begin
                  state_d = StFault;
               end
            end
         end
         StT2: begin
            busy    = 1'b1;
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = StT3;
         end
         StT3: begin
            busy = 1'b1;
            if (op <= OpRLast) begin
               reg_out = reg_sel(rb);
               RYin    = 1'b1;
               state_d = StT4;
            end else if (op == OpHalt) begin
               state_d = StHalt;
            end else begin
               illegal = (op != OpNop);
               done    = 1'b1;
               state_d = run ? StT0 : StIdle;
            end
         end
         StT4: begin
            busy    = 1'b1;
            reg_out = reg_sel(rc);
            alu_op  = op;
            RZinLo  = 1'b1;
            state_d = StT5;
         end
         StT5: begin
            busy    = 1'b1;
            RZoutLo = 1'b1;
            reg_in  = reg_sel(ra);
            done    = 1'b1;
            state_d = run ? StT0 : StIdle;
         end
         StHalt: begin
            halted = 1'b1;
         end
         StFault: begin
            fault = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control unit that sequences the bus-based datapath: fetch, decode and execute of three-register ALU instructions.
- Drives the datapath's register in/out strobes, PC/IR/MDR/MAR/Y/Z controls and the ALU opcode.
- Handshakes with memory for instruction reads and reports done, halt and fault status to the top level.

Parameters:
- MEM_TIMEOUT, 15, max cycles spent in T1 waiting for mem_ready before entering FAULT (legal range 1..255).
- NREGS, 16, number of general-purpose registers; width of reg_in/reg_out.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- clear  input  1  asynchronous active-low reset
- run  input  1  level; while high the sequencer keeps fetching
- mem_ready  input  1  memory read data valid on Mdatain this cycle
- ir  input  32  current instruction register contents; op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
- PCout, PCin, IncPC, MARin  output  1 each  PC/MAR strobes
- MDRread, MDRin, MDRout, IRin  output  1 each  MDR/IR strobes
- RYin, RZinLo, RZoutLo  output  1 each  Y/Z strobes
- reg_in  output  NREGS  one-hot GPR load enable
- reg_out  output  NREGS  one-hot GPR bus drive
- alu_op  output  5  ALU opcode; 0 when not in T4
- busy  output  1  high in any state other than IDLE/HALT/FAULT
- done  output  1  one-cycle pulse on completion of each instruction
- halted  output  1  high in HALT
- fault  output  1  high in FAULT
- illegal  output  1  one-cycle pulse in T3 for an undefined opcode

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT, FAULT; 4-bit state register, async reset to IDLE.
- Reset (clear=0): state=IDLE, timeout counter=0; all outputs 0 while in reset and in IDLE.
- Outputs are combinational decode of the state, plus mem_ready for MDRin. At most one bus-drive strobe is active per cycle: PCout, MDRout, RZoutLo or a reg_out bit.
- IDLE: run=1 -> T0; else stay.
- T0: PCout, MARin, IncPC, RZinLo -> T1; counter cleared.
- T1 (memory wait): MDRread=1 and RZoutLo=1 every cycle. PCin=1 only on the first T1 cycle, so PC updates exactly once.
  - mem_ready=1 -> MDRin=1 that cycle, next state T2.
  - mem_ready=0 -> counter increments. Counter reaching MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - mem_ready=1 on the timeout cycle wins: go to T2.
- T2: MDRout, IRin -> T3.
- T3 (decode, op=ir[31:27]):
  - R-type op 00000..01000 (add, sub, and, or, shr, shra, shl, ror, rol): reg_out[rb]=1, RYin=1 -> T4.
  - 11010 nop: done=1 -> T0 if run else IDLE.
  - 11011 halt: -> HALT.
  - Any other op: illegal=1, done=1, treated as nop.
- T4: reg_out[rc]=1, alu_op=op, RZinLo=1 -> T5.
- T5: RZoutLo=1, reg_in[ra]=1, done=1 -> T0 if run else IDLE.
- Register fields ra/rb/rc equal to each other are legal. Indices >= NREGS produce no strobe and are not flagged as illegal.
- Dropping run mid-instruction has no effect: the current instruction completes, then the sequencer goes to IDLE.
- HALT and FAULT are sticky. They hold all strobes at 0 and ignore run; only clear exits them.
- ir is sampled combinationally in T3..T5; it must be stable from T2 exit to T5 (guaranteed by IRin timing).
- Reset asserted in any state, including mid-wait in T1: immediate return to IDLE with all outputs 0. No partial write occurs after reset.
- Latency: R-type = 6 cycles + (mem wait cycles); nop = 4 + wait.

Test Plan:
- clear=0 for 3 cycles, then clear=1 with run=0 -> stays IDLE, all outputs 0, busy=0.
- run=1, mem_ready=1 in first T1 cycle, ir=0x00918000 (add r1,r2,r3) -> T0..T5 in 6 cycles; T3 reg_out=0x0004+RYin; T4 reg_out=0x0008, alu_op=0; T5 reg_in=0x0002, done pulse.
- mem_ready held low for 3 cycles -> T1 lasts 4 cycles, PCin high only first cycle, MDRin high only in 4th; instruction then completes normally.
- mem_ready never asserted, MEM_TIMEOUT=15 -> FAULT entered after 15 T1 cycles, fault=1, run toggling ignored; clear pulse -> IDLE.
- ir op=11111 -> illegal and done pulse in T3, no reg_in activity, next fetch starts; ir op=11011 -> halted=1 sticky.
- clear deasserted-low during T4 -> outputs 0 same cycle, state IDLE, no reg_in pulse afterward.
